// File: rtl/dac_pkg.sv
// Shared definitions for the LTC2604 write path: command/address codes,
// default frame timing, sequencer state encoding and the queued word layout.
package dac_pkg;

    localparam logic [3:0] CMD_WRITE        = 4'b0000;
    localparam logic [3:0] CMD_UPDATE       = 4'b0001;
    localparam logic [3:0] CMD_WRITE_UPDATE = 4'b0011;
    localparam logic [3:0] CMD_POWER_DOWN   = 4'b0100;

    localparam logic [3:0] ADDR_A   = 4'b0000;
    localparam logic [3:0] ADDR_B   = 4'b0001;
    localparam logic [3:0] ADDR_C   = 4'b0010;
    localparam logic [3:0] ADDR_D   = 4'b0011;
    localparam logic [3:0] ADDR_ALL = 4'b1111;

    localparam int DEFAULT_DEPTH        = 8;
    localparam int DEFAULT_FRAME_CYCLES = 26;
    localparam int DEFAULT_GAP_CYCLES   = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2
    } seq_state_t;

    typedef struct packed {
        logic [3:0]  cmd;
        logic [3:0]  addr;
        logic [15:0] value;
    } dac_word_t;

endpackage

// File: rtl/dac_write_sequencer_if.sv
// Bus-side write request channel into the DAC write sequencer.
interface dac_write_sequencer_if;
    logic        wr_en;
    logic [3:0]  wr_cmd;
    logic [3:0]  wr_addr;
    logic [15:0] wr_value;
    logic        wr_ready;

    modport master (output wr_en, output wr_cmd, output wr_addr, output wr_value, input wr_ready);
    modport slave  (input wr_en, input wr_cmd, input wr_addr, input wr_value, output wr_ready);
endinterface

// File: rtl/dac_cmd_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy level and flush.
// A push while full is ignored here; the caller decides how to report it.
module dac_cmd_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 24
) (
    input  logic                     clk25,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [LW-1:0]    level_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full  = (level_r == LW'(DEPTH));
    assign empty = (level_r == {LW{1'b0}});
    assign level = level_r;
    assign dout  = mem_r[rd_ptr_r];

    // Accept qualification: flush discards a same-cycle push
    always_comb begin
        push_ok_s = push && !full && !flush;
        pop_ok_s  = pop && !empty;
    end

    // Pointers and level
    always_ff @(posedge clk25) begin
        if (reset || flush) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            level_r  <= {LW{1'b0}};
        end else begin
            if (push_ok_s) wr_ptr_r <= wr_ptr_r + AW'(1);
            if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
            case ({push_ok_s, pop_ok_s})
                2'b10:   level_r <= level_r + LW'(1);
                2'b01:   level_r <= level_r - LW'(1);
                default: level_r <= level_r;
            endcase
        end
    end

    // Storage array, no reset needed since level gates visibility
    always_ff @(posedge clk25) begin
        if (push_ok_s) mem_r[wr_ptr_r] <= din;
    end

endmodule

// File: rtl/dac_write_sequencer.sv
// Queues LTC2604 write requests and launches them one at a time into the SPI
// serializer, spacing launches by a fixed frame time since it has no done flag.
module dac_write_sequencer
    import dac_pkg::*;
#(
    parameter int DEPTH        = DEFAULT_DEPTH,
    parameter int FRAME_CYCLES = DEFAULT_FRAME_CYCLES,
    parameter int GAP_CYCLES   = DEFAULT_GAP_CYCLES
) (
    input  logic                     clk25,
    input  logic                     reset,
    dac_write_sequencer_if.slave     wr,
    input  logic                     flush,
    input  logic                     clear_overflow,
    output logic                     tx_data,
    output logic [3:0]               cmd,
    output logic [3:0]               addr,
    output logic [15:0]              value,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     overflow,
    output logic [15:0]              frames_sent
);
    localparam int PACE = FRAME_CYCLES + GAP_CYCLES - 2;
    localparam int CW   = $clog2(PACE + 2);

    seq_state_t state_r;
    seq_state_t next_state_s;
    logic [CW-1:0] pace_cnt_r;
    logic          dispatch_s;
    logic          drop_s;
    logic          fifo_full_s;
    logic          fifo_empty_s;
    dac_word_t     wr_word_s;
    dac_word_t     head_s;
    logic [23:0]   head_raw_s;

    assign wr_word_s   = '{cmd: wr.wr_cmd, addr: wr.wr_addr, value: wr.wr_value};
    assign head_s      = dac_word_t'(head_raw_s);
    assign wr.wr_ready = !fifo_full_s;
    assign busy        = (state_r != ST_IDLE) || !fifo_empty_s;

    dac_cmd_fifo #(.DEPTH(DEPTH), .WIDTH(24)) u_fifo (
        .clk25 (clk25),
        .reset (reset),
        .push  (wr.wr_en),
        .pop   (dispatch_s),
        .flush (flush),
        .din   (wr_word_s),
        .dout  (head_raw_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .level (fifo_level)
    );

    // State register
    always_ff @(posedge clk25) begin
        if (reset) state_r <= ST_IDLE;
        else       state_r <= next_state_s;
    end

    // Next-state logic; the pacing counter reaching its last count ends the frame
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE:   next_state_s = fifo_empty_s ? ST_IDLE : ST_LAUNCH;
            ST_LAUNCH: next_state_s = ST_WAIT;
            ST_WAIT:   next_state_s = (pace_cnt_r <= CW'(1)) ? ST_IDLE : ST_WAIT;
            default:   next_state_s = ST_IDLE;
        endcase
    end

    // Output decode: dispatch pops the head; a write into a full FIFO is dropped
    always_comb begin
        dispatch_s = 1'b0;
        if (state_r == ST_IDLE) dispatch_s = !fifo_empty_s;
        else                    dispatch_s = 1'b0;
        drop_s = wr.wr_en && fifo_full_s && !flush;
    end

    // Registered serializer word, launch strobe, pacing counter and status
    always_ff @(posedge clk25) begin
        if (reset) begin
            tx_data     <= 1'b0;
            cmd         <= 4'd0;
            addr        <= 4'd0;
            value       <= 16'd0;
            pace_cnt_r  <= {CW{1'b0}};
            frames_sent <= 16'd0;
            overflow    <= 1'b0;
        end else begin
            tx_data  <= dispatch_s;
            overflow <= (overflow && !clear_overflow) || drop_s;
            if (dispatch_s) begin
                cmd         <= head_s.cmd;
                addr        <= head_s.addr;
                value       <= head_s.value;
                frames_sent <= frames_sent + 16'd1;
                pace_cnt_r  <= CW'(PACE);
            end else if (state_r == ST_WAIT && pace_cnt_r != {CW{1'b0}}) begin
                pace_cnt_r  <= pace_cnt_r - CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_dac_write_sequencer.sv
// Randomized and directed bench for dac_write_sequencer against a queue-based
// model: launches allowed once the queue is non-empty and 28 cycles have elapsed.
module tb_dac_write_sequencer;
    import dac_pkg::*;

    localparam int DEPTH  = 8;
    localparam int PERIOD = 28;

    logic        clk25 = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        clear_overflow = 1'b0;
    logic        tx_data;
    logic [3:0]  cmd;
    logic [3:0]  addr;
    logic [15:0] value;
    logic        busy;
    logic [3:0]  fifo_level;
    logic        overflow;
    logic [15:0] frames_sent;

    int tests = 0;
    int fails = 0;

    dac_write_sequencer_if wif ();

    dac_write_sequencer #(.DEPTH(DEPTH), .FRAME_CYCLES(26), .GAP_CYCLES(2)) dut (
        .clk25          (clk25),
        .reset          (reset),
        .wr             (wif),
        .flush          (flush),
        .clear_overflow (clear_overflow),
        .tx_data        (tx_data),
        .cmd            (cmd),
        .addr           (addr),
        .value          (value),
        .busy           (busy),
        .fifo_level     (fifo_level),
        .overflow       (overflow),
        .frames_sent    (frames_sent)
    );

    always #20 clk25 = ~clk25;

    // Behavioural model state
    logic [23:0] q[$];
    int          cyc = 0;
    int          m_last = 0;
    bit          m_launched = 0;
    bit          m_valid = 0;
    logic        m_tx = 1'b0;
    logic        m_ov = 1'b0;
    logic [15:0] m_frames = 16'd0;
    logic [23:0] m_word = 24'd0;

    int          pulse_cyc[$];
    logic [15:0] pulse_val[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model update on each rising edge using the inputs held since the last falling edge
    always @(posedge clk25) begin
        int   pre;
        logic drop;
        cyc++;
        if (reset) begin
            q.delete();
            m_launched = 0;
            m_tx = 1'b0;
            m_ov = 1'b0;
            m_frames = 16'd0;
            m_word = 24'd0;
            m_valid = 1;
        end else begin
            pre = q.size();
            m_tx = 1'b0;
            if (pre > 0 && (!m_launched || cyc - m_last >= PERIOD)) begin
                m_word = q.pop_front();
                m_frames = m_frames + 16'd1;
                m_last = cyc;
                m_launched = 1;
                m_tx = 1'b1;
            end
            drop = 1'b0;
            if (flush) q.delete();
            else if (wif.wr_en) begin
                if (pre == DEPTH) drop = 1'b1;
                else q.push_back({wif.wr_cmd, wif.wr_addr, wif.wr_value});
            end
            m_ov = (m_ov && !clear_overflow) || drop;
        end
    end

    // Compare process: every falling edge once the model has seen a reset
    always @(negedge clk25) begin
        logic m_busy;
        if (m_valid) begin
            m_busy = (q.size() > 0) || (m_launched && (cyc - m_last) <= PERIOD - 2);
            check("tx_data", {31'd0, tx_data}, {31'd0, m_tx});
            check("cmd", {28'd0, cmd}, {28'd0, m_word[23:20]});
            check("addr", {28'd0, addr}, {28'd0, m_word[19:16]});
            check("value", {16'd0, value}, {16'd0, m_word[15:0]});
            check("fifo_level", {28'd0, fifo_level}, 32'(q.size()));
            check("wr_ready", {31'd0, wif.wr_ready}, {31'd0, (q.size() < DEPTH)});
            check("busy", {31'd0, busy}, {31'd0, m_busy});
            check("overflow", {31'd0, overflow}, {31'd0, m_ov});
            check("frames_sent", {16'd0, frames_sent}, {16'd0, m_frames});
            if (tx_data === 1'b1) begin
                pulse_cyc.push_back(cyc);
                pulse_val.push_back(value);
            end
        end
    end

    task automatic drive(input logic we, input logic [3:0] c, input logic [3:0] a,
                         input logic [15:0] v, input logic fl, input logic clr, input logic rst);
        @(negedge clk25);
        wif.wr_en = we; wif.wr_cmd = c; wif.wr_addr = a; wif.wr_value = v;
        flush = fl; clear_overflow = clr; reset = rst;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 4'd0, 4'd0, 16'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic wr(input logic [3:0] c, input logic [3:0] a, input logic [15:0] v);
        drive(1'b1, c, a, v, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        drive(1'b0, 4'd0, 4'd0, 16'd0, 1'b0, 1'b0, 1'b1);
        idle(1);
        pulse_cyc.delete();
        pulse_val.delete();
    endtask

    initial begin
        int we;
        wif.wr_en = 1'b0; wif.wr_cmd = 4'd0; wif.wr_addr = 4'd0; wif.wr_value = 16'd0;
        repeat (3) @(posedge clk25);
        do_reset();

        // Idle after reset
        idle(50);
        check("idle_pulses", 32'(pulse_cyc.size()), 32'd0);
        check("idle_ready", {31'd0, wif.wr_ready}, 32'd1);

        // Single write
        wr(CMD_WRITE_UPDATE, ADDR_B, 16'hBEEF);
        we = cyc + 1;
        idle(40);
        check("single_pulses", 32'(pulse_cyc.size()), 32'd1);
        if (pulse_cyc.size() == 1) check("single_latency", 32'(pulse_cyc[0]), 32'(we + 1));
        check("single_cmd", {28'd0, cmd}, 32'd3);
        check("single_addr", {28'd0, addr}, 32'd1);
        check("single_value", {16'd0, value}, 32'h0000BEEF);
        check("single_frames", {16'd0, frames_sent}, 32'd1);
        check("single_busy", {31'd0, busy}, 32'd0);

        // Burst of 8
        pulse_cyc.delete(); pulse_val.delete();
        for (int i = 0; i < 8; i++) wr(CMD_WRITE, ADDR_A, 16'(i));
        idle(8 * PERIOD + 10);
        check("burst_pulses", 32'(pulse_cyc.size()), 32'd8);
        if (pulse_cyc.size() == 8) begin
            for (int i = 1; i < 8; i++) check("burst_gap", 32'(pulse_cyc[i] - pulse_cyc[i-1]), 32'd28);
            for (int i = 0; i < 8; i++) check("burst_order", {16'd0, pulse_val[i]}, 32'(i));
        end
        check("burst_frames", {16'd0, frames_sent}, 32'd9);

        // Overflow: 10 back-to-back writes
        do_reset();
        for (int i = 0; i < 10; i++) wr(CMD_WRITE, ADDR_C, 16'h0100 + 16'(i));
        idle(1);
        check("ovf_ready_low", {31'd0, wif.wr_ready}, 32'd0);
        check("ovf_level", {28'd0, fifo_level}, 32'd8);
        idle(9 * PERIOD + 10);
        check("ovf_pulses", 32'(pulse_cyc.size()), 32'd9);
        check("ovf_flag", {31'd0, overflow}, 32'd1);
        drive(1'b0, 4'd0, 4'd0, 16'd0, 1'b0, 1'b1, 1'b0);
        idle(1);
        check("ovf_cleared", {31'd0, overflow}, 32'd0);

        // Flush after a 4-write burst, with a same-cycle write
        do_reset();
        for (int i = 0; i < 4; i++) wr(CMD_WRITE, ADDR_D, 16'h0200 + 16'(i));
        idle(2);
        drive(1'b1, CMD_WRITE, ADDR_D, 16'h0299, 1'b1, 1'b0, 1'b0);
        idle(3 * PERIOD);
        check("flush_pulses", 32'(pulse_cyc.size()), 32'd1);
        check("flush_level", {28'd0, fifo_level}, 32'd0);
        check("flush_overflow", {31'd0, overflow}, 32'd0);
        check("flush_value", {16'd0, value}, 32'h00000200);

        // Reset in the middle of the wait phase
        do_reset();
        wr(CMD_POWER_DOWN, ADDR_ALL, 16'h1234);
        idle(10);
        drive(1'b0, 4'd0, 4'd0, 16'd0, 1'b0, 1'b0, 1'b1);
        idle(1);
        check("rst_frames", {16'd0, frames_sent}, 32'd0);
        check("rst_tx", {31'd0, tx_data}, 32'd0);
        check("rst_level", {28'd0, fifo_level}, 32'd0);
        wr(CMD_UPDATE, ADDR_A, 16'h5A5A);
        we = cyc + 1;
        idle(5);
        check("rst_relaunch", 32'(pulse_cyc[pulse_cyc.size()-1]), 32'(we + 1));
        check("rst_relaunch_frames", {16'd0, frames_sent}, 32'd1);

        // Randomized traffic
        for (int i = 0; i < 2500; i++) begin
            drive(($urandom_range(0, 99) < 30) ? 1'b1 : 1'b0,
                  4'($urandom), 4'($urandom), 16'($urandom),
                  ($urandom_range(0, 63) == 0) ? 1'b1 : 1'b0,
                  ($urandom_range(0, 15) == 0) ? 1'b1 : 1'b0,
                  ($urandom_range(0, 599) == 0) ? 1'b1 : 1'b0);
        end
        idle(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
